// File: rtl/multi_channel_accumulator.sv
// Per-channel signed window accumulator with wrap/saturate arithmetic,
// sticky overflow flags and a valid/ready handshake on the window result.
module multi_channel_accumulator #(
    parameter  int unsigned NB_DATA = 8,
    parameter  int unsigned NB_ACC  = 12,
    parameter  int unsigned N_CH    = 8,
    parameter  int unsigned ACC_LEN = 16,
    localparam int unsigned NB_CNT  = $clog2(ACC_LEN + 1)
) (
    input  logic                      clock,
    input  logic                      i_reset,
    input  logic [NB_DATA*N_CH-1:0]   i_data,
    input  logic                      i_valid,
    output logic                      o_ready,
    input  logic [N_CH-1:0]           i_ch_en,
    input  logic                      i_sat_mode,
    input  logic                      i_clear,
    output logic [NB_ACC*N_CH-1:0]    o_data,
    output logic [N_CH-1:0]           o_ovf,
    output logic                      o_valid,
    input  logic                      i_ready,
    output logic [NB_CNT-1:0]         o_count
);

    localparam int unsigned NB_SUM = NB_ACC + 1;

    localparam logic [0:0] ST_ACC  = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    logic [0:0]                r_state;
    logic [0:0]                w_state_next;
    logic                      r_ready;
    logic                      r_valid;
    logic [NB_CNT-1:0]         r_count;
    logic signed [NB_ACC-1:0]  r_acc [N_CH];
    logic [N_CH-1:0]           r_sticky;
    logic [NB_ACC*N_CH-1:0]    r_data;
    logic [N_CH-1:0]           r_ovf;

    logic                      w_accept;
    logic                      w_last;
    logic signed [NB_ACC-1:0]  w_acc_upd [N_CH];
    logic [N_CH-1:0]           w_ovf_hit;
    logic [NB_ACC*N_CH-1:0]    w_data_flat;

    assign w_accept = i_valid && r_ready;
    assign w_last   = w_accept && (r_count == NB_CNT'(ACC_LEN - 1));

    // Per-channel add with one guard bit to detect signed overflow
    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        logic signed [NB_DATA-1:0] w_sample;
        logic signed [NB_SUM-1:0]  w_sum;
        logic                      w_ovf;
        logic [NB_ACC-1:0]         w_sat;
        logic [NB_ACC-1:0]         w_new;

        assign w_sample = i_data[k*NB_DATA +: NB_DATA];
        assign w_sum    = NB_SUM'(w_sample) + NB_SUM'(r_acc[k]);
        assign w_ovf    = w_sum[NB_ACC] ^ w_sum[NB_ACC-1];
        assign w_sat    = w_sum[NB_ACC] ? {1'b1, {(NB_ACC-1){1'b0}}}
                                        : {1'b0, {(NB_ACC-1){1'b1}}};
        assign w_new    = (w_ovf && i_sat_mode) ? w_sat : w_sum[NB_ACC-1:0];

        assign w_acc_upd[k]                     = i_ch_en[k] ? w_new : r_acc[k];
        assign w_ovf_hit[k]                     = i_ch_en[k] & w_ovf;
        assign w_data_flat[k*NB_ACC +: NB_ACC]  = w_acc_upd[k];
    end

    // Next-state logic; clear forces the accumulate state
    always_comb begin
        w_state_next = r_state;
        if (i_clear) begin
            w_state_next = ST_ACC;
        end else begin
            case (r_state)
                ST_ACC:  if (w_last)  w_state_next = ST_HOLD;
                ST_HOLD: if (i_ready) w_state_next = ST_ACC;
                default: w_state_next = ST_ACC;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (i_reset) begin
            r_state <= ST_ACC;
            r_ready <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_ready <= (w_state_next == ST_ACC);
        end
    end

    // Accumulators, window counter and result registers
    always_ff @(posedge clock) begin
        if (i_reset) begin
            for (int unsigned k = 0; k < N_CH; k++) r_acc[k] <= '0;
            r_sticky <= '0;
            r_count  <= '0;
            r_valid  <= 1'b0;
            r_data   <= '0;
            r_ovf    <= '0;
        end else if (i_clear) begin
            for (int unsigned k = 0; k < N_CH; k++) r_acc[k] <= '0;
            r_sticky <= '0;
            r_count  <= '0;
            r_valid  <= 1'b0;
        end else begin
            if (r_state == ST_HOLD && i_ready) begin
                r_valid <= 1'b0;
            end
            if (w_last) begin
                r_data   <= w_data_flat;
                r_ovf    <= r_sticky | w_ovf_hit;
                r_valid  <= 1'b1;
                for (int unsigned k = 0; k < N_CH; k++) r_acc[k] <= '0;
                r_sticky <= '0;
                r_count  <= '0;
            end else if (w_accept) begin
                for (int unsigned k = 0; k < N_CH; k++) r_acc[k] <= w_acc_upd[k];
                r_sticky <= r_sticky | w_ovf_hit;
                r_count  <= r_count + NB_CNT'(1);
            end
        end
    end

    assign o_ready = r_ready;
    assign o_valid = r_valid;
    assign o_count = r_count;
    assign o_data  = r_data;
    assign o_ovf   = r_ovf;

endmodule
